cordic_cos_pipeline: RTL and testbench



---
 rtl/cordic_cos_pipeline.sv | 185 ++++++++++++++++++
 tb/tb_cordic_cos_pipeline.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_cos_pipeline.sv
// Highest-set-bit finder for one byte; index is 0 when no bit is set.
// Latency: combinational.
// Backpressure: none.
module priority_encoder8 (
  input  logic [7:0] data,
  output logic [2:0] index,
  output logic       valid
);
  always_comb begin
    index = '0;
    for (int i = 0; i < 8; i++) begin
      if (data[i]) index = 3'(i);
    end
  end

  assign valid = |data;
endmodule

// Highest-set-bit finder for a 32-bit word; index is 0 when no bit is set.
// Latency: combinational.
// Backpressure: none.
module priority_encoder32 (
  input  logic [31:0] data,
  output logic [4:0]  index,
  output logic        valid
);
  logic [2:0] sub_idx [4];
  logic [3:0] grp_vld;
  logic [2:0] grp_idx;
  logic       unused_grp_msb;

  for (genvar g = 0; g < 4; g++) begin : g_grp
    priority_encoder8 u_grp (
      .data  (data[8*g +: 8]),
      .index (sub_idx[g]),
      .valid (grp_vld[g])
    );
  end

  // Only four groups exist, so the select encoder's top bit is always 0.
  priority_encoder8 u_sel (
    .data  ({4'b0000, grp_vld}),
    .index (grp_idx),
    .valid (valid)
  );

  assign unused_grp_msb = grp_idx[2];
  assign index          = {grp_idx[1:0], sub_idx[grp_idx[1:0]]};
endmodule

// Pipelined CORDIC cosine: float angle in [0,1] rad -> float cos.
// Latency: 16 enabled clocks (float->fixed, ITER rotations, fixed->float).
// Backpressure: none; clk_en=0 freezes every stage.
module cordic_cos_pipeline #(
  parameter int ITER = 14,
  parameter int FW   = 21
) (
  input  logic          clock,
  input  logic          aclr,
  input  logic          clk_en,
  input  logic [31:0]   dataa,
  output logic [31:0]   result,
  output logic [4:0]    rotate_index_debug,
  output logic [FW-1:0] x_debug,
  output logic [FW-1:0] z_debug,
  output logic [FW-1:0] fixed_point_input_debug,
  output logic [7:0]    exponent_debug,
  output logic [FW-1:0] fixed_point_result_debug
);
  localparam int FRAC = FW - 2;
  localparam logic signed [FW-1:0] K = FW'(318376);

  function automatic logic signed [FW-1:0] atan_lut(input int i);
    case (i)
      0:       atan_lut = FW'(411775);
      1:       atan_lut = FW'(243085);
      2:       atan_lut = FW'(128439);
      3:       atan_lut = FW'(65198);
      4:       atan_lut = FW'(32725);
      5:       atan_lut = FW'(16379);
      6:       atan_lut = FW'(8191);
      7:       atan_lut = FW'(4096);
      default: atan_lut = FW'((1 << FRAC) >> i);
    endcase
  endfunction

  logic [7:0]           exp_in;
  logic [23:0]          mant_in;
  logic [FW-1:0]        angle_d, angle_q;
  logic [7:0]           exp_q;
  logic                 unused_sign;

  assign exp_in      = dataa[30:23];
  assign mant_in     = {1'b1, dataa[22:0]};
  assign unused_sign = dataa[31];

  // Oversized exponents reuse the e=127 alignment so the output stays deterministic.
  always_comb begin
    angle_d = '0;
    if (dataa[30:0] != 31'd0 && exp_in >= 8'd108) begin
      if (exp_in >= 8'd127) angle_d = FW'(mant_in >> 4);
      else                  angle_d = FW'(mant_in >> (8'd131 - exp_in));
    end
  end

  logic signed [FW-1:0] x_in [ITER], y_in [ITER], z_in [ITER];
  logic signed [FW-1:0] x_d  [ITER], y_d  [ITER], z_d  [ITER];
  logic signed [FW-1:0] x_q  [ITER], y_q  [ITER], z_q  [ITER];
  logic                 unused_y;

  assign unused_y = ^y_q[ITER-1];

  always_comb begin
    x_in[0] = K;
    y_in[0] = '0;
    z_in[0] = $signed(angle_q);
    for (int i = 1; i < ITER; i++) begin
      x_in[i] = x_q[i-1];
      y_in[i] = y_q[i-1];
      z_in[i] = z_q[i-1];
    end
    for (int i = 0; i < ITER; i++) begin
      if (z_in[i][FW-1]) begin
        x_d[i] = x_in[i] + (y_in[i] >>> i);
        y_d[i] = y_in[i] - (x_in[i] >>> i);
        z_d[i] = z_in[i] + atan_lut(i);
      end else begin
        x_d[i] = x_in[i] - (y_in[i] >>> i);
        y_d[i] = y_in[i] + (x_in[i] >>> i);
        z_d[i] = z_in[i] - atan_lut(i);
      end
    end
  end

  logic [31:0] fx, norm, res_d;
  logic [4:0]  lead_pos;
  logic        lead_vld;
  logic [8:0]  unused_norm;

  assign fx = {{(32-FW){1'b0}}, x_q[ITER-1]};

  priority_encoder32 u_lead (
    .data  (fx),
    .index (lead_pos),
    .valid (lead_vld)
  );

  // Leading one moves to bit 31; the 23 bits beneath it form the mantissa.
  assign norm        = fx << (5'd31 - lead_pos);
  assign unused_norm = {norm[31], norm[7:0]};
  assign res_d       = lead_vld ? {1'b0, 8'(127 - FRAC) + {3'b000, lead_pos}, norm[30:8]} : '0;

  always_ff @(posedge clock) begin
    if (aclr) begin
      angle_q <= '0;
      exp_q   <= '0;
      result  <= '0;
      for (int i = 0; i < ITER; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
        z_q[i] <= '0;
      end
    end else if (clk_en) begin
      angle_q <= angle_d;
      exp_q   <= exp_in;
      result  <= res_d;
      for (int i = 0; i < ITER; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
        z_q[i] <= z_d[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (aclr) rotate_index_debug <= '0;
    else      rotate_index_debug <= 5'(ITER - 1);
  end

  assign x_debug                  = x_q[ITER-1];
  assign z_debug                  = z_q[ITER-1];
  assign fixed_point_result_debug = x_q[ITER-1];
  assign fixed_point_input_debug  = angle_q;
  assign exponent_debug           = exp_q;
endmodule

// File: tb/tb_cordic_cos_pipeline.sv
// Directed bench for cordic_cos_pipeline and its priority encoders.
module tb_cordic_cos_pipeline;
  localparam int  FW  = 21;
  localparam real TOL = 0.000244140625;

  logic          clock = 1'b0;
  logic          aclr, clk_en;
  logic [31:0]   dataa, result;
  logic [4:0]    rotate_index_debug;
  logic [FW-1:0] x_debug, z_debug, fixed_point_input_debug, fixed_point_result_debug;
  logic [7:0]    exponent_debug;

  logic [31:0] pe32_data;
  logic [4:0]  pe32_index;
  logic        pe32_valid;
  logic [7:0]  pe8_data;
  logic [2:0]  pe8_index;
  logic        pe8_valid;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] vec [11] = '{32'h00000000, 32'h3DCCCCCD, 32'h3E4CCCCD, 32'h3E99999A,
                            32'h3ECCCCCD, 32'h3F000000, 32'h3F19999A, 32'h3F333333,
                            32'h3F4CCCCD, 32'h3F666666, 32'h3F800000};
  real cosv [11] = '{1.0, 0.995004165, 0.980066578, 0.955336489, 0.921060994, 0.877582562,
                     0.825335615, 0.764842187, 0.696706709, 0.621609968, 0.540302306};

  cordic_cos_pipeline dut (
    .clock                    (clock),
    .aclr                     (aclr),
    .clk_en                   (clk_en),
    .dataa                    (dataa),
    .result                   (result),
    .rotate_index_debug       (rotate_index_debug),
    .x_debug                  (x_debug),
    .z_debug                  (z_debug),
    .fixed_point_input_debug  (fixed_point_input_debug),
    .exponent_debug           (exponent_debug),
    .fixed_point_result_debug (fixed_point_result_debug)
  );

  priority_encoder32 u_pe32 (.data(pe32_data), .index(pe32_index), .valid(pe32_valid));
  priority_encoder8  u_pe8  (.data(pe8_data),  .index(pe8_index),  .valid(pe8_valid));

  always #5 clock = ~clock;

  function automatic real f2r(input logic [31:0] b);
    real m;
    int  e;
    e = int'(b[30:23]);
    if (e == 0) return 0.0;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    for (int k = 127; k < e; k++) m = m * 2.0;
    for (int k = e; k < 127; k++) m = m / 2.0;
    if (b[31]) m = -m;
    return m;
  endfunction

  function automatic real absr(input real v);
    return (v < 0.0) ? -v : v;
  endfunction

  task automatic test_reset();
    aclr = 1'b1; clk_en = 1'b0; dataa = 32'h3F800000;
    repeat (2) @(negedge clock);
    n_checks++; if (result !== 32'h0) begin n_errors++; $display("FAIL reset_result: got %h want 0", result); end
    n_checks++; if (rotate_index_debug !== 5'd0) begin n_errors++; $display("FAIL reset_rotate: got %0d want 0", rotate_index_debug); end
    n_checks++; if (x_debug !== '0) begin n_errors++; $display("FAIL reset_x: got %h want 0", x_debug); end
    n_checks++; if (z_debug !== '0) begin n_errors++; $display("FAIL reset_z: got %h want 0", z_debug); end
    n_checks++; if (fixed_point_input_debug !== '0) begin n_errors++; $display("FAIL reset_fpi: got %h want 0", fixed_point_input_debug); end
    n_checks++; if (exponent_debug !== 8'd0) begin n_errors++; $display("FAIL reset_exp: got %h want 0", exponent_debug); end
    n_checks++; if (fixed_point_result_debug !== '0) begin n_errors++; $display("FAIL reset_fpr: got %h want 0", fixed_point_result_debug); end
    aclr = 1'b0; clk_en = 1'b1; dataa = 32'h0;
    @(negedge clock);
    n_checks++; if (rotate_index_debug !== 5'd13) begin n_errors++; $display("FAIL rotate_index: got %0d want 13", rotate_index_debug); end
  endtask

  task automatic test_float_to_fixed();
    logic [31:0]   f_in  [6] = '{32'h3F800000, 32'h3F000000, 32'h3DCCCCCD, 32'h35800000, 32'h36000000, 32'h00000000};
    logic [FW-1:0] f_fix [6] = '{21'd524288, 21'd262144, 21'd52428, 21'd0, 21'd1, 21'd0};
    logic [7:0]    f_exp [6] = '{8'd127, 8'd126, 8'd123, 8'd107, 8'd108, 8'd0};
    for (int i = 0; i < 6; i++) begin
      dataa = f_in[i]; clk_en = 1'b1;
      @(negedge clock);
      n_checks++;
      if ({fixed_point_input_debug, exponent_debug} !== {f_fix[i], f_exp[i]}) begin
        n_errors++;
        $display("FAIL f2fix[%0d] in=%h: got fix=%0d exp=%0d want fix=%0d exp=%0d",
                 i, f_in[i], fixed_point_input_debug, exponent_debug, f_fix[i], f_exp[i]);
      end
    end
  endtask

  task automatic test_single();
    for (int j = 0; j < 23; j++) begin
      dataa = (j == 4) ? 32'h00000000 : 32'h3F800000; clk_en = 1'b1;
      @(negedge clock);
      if (j == 18 || j == 20) begin
        n_checks++;
        if (absr(f2r(result) - 0.540302306) > TOL) begin
          n_errors++; $display("FAIL single_neighbour[%0d]: got %h want ~0.540302", j, result);
        end
      end
      if (j == 19) begin
        n_checks++;
        if (absr(f2r(result) - 1.0) > TOL) begin
          n_errors++; $display("FAIL single_zero: got %h want ~1.0", result);
        end
        n_checks++;
        if (!(result[31:23] == 9'd126 || result[31:23] == 9'd127)) begin
          n_errors++; $display("FAIL single_zero_exp: got sign/exp %h want 07E or 07F", result[31:23]);
        end
      end
    end
  endtask

  task automatic test_stream();
    for (int j = 0; j < 26; j++) begin
      dataa = (j < 11) ? vec[j] : 32'h0; clk_en = 1'b1;
      @(negedge clock);
      if (j >= 15) begin
        n_checks++;
        if (result[31] !== 1'b0 || absr(f2r(result) - cosv[j-15]) > TOL) begin
          n_errors++; $display("FAIL stream[%0d]: got %h want ~%f", j-15, result, cosv[j-15]);
        end
      end
    end
  endtask

  task automatic test_stall();
    int            ne = 0;
    logic [31:0]   prev_res;
    logic [FW-1:0] prev_x, prev_z, prev_fi;
    for (int j = 0; j < 32; j++) begin
      logic stall;
      stall    = (j >= 17 && j < 22);
      clk_en   = !stall;
      dataa    = stall ? 32'h3F19999A : ((ne < 11) ? vec[ne] : 32'h0);
      prev_res = result; prev_x = x_debug; prev_z = z_debug; prev_fi = fixed_point_input_debug;
      @(negedge clock);
      if (stall) begin
        n_checks++;
        if (result !== prev_res) begin
          n_errors++; $display("FAIL stall_result[%0d]: got %h want %h", j, result, prev_res);
        end
        n_checks++;
        if ({x_debug, z_debug, fixed_point_input_debug} !== {prev_x, prev_z, prev_fi}) begin
          n_errors++; $display("FAIL stall_debug[%0d]: got %h/%h/%h want %h/%h/%h",
                               j, x_debug, z_debug, fixed_point_input_debug, prev_x, prev_z, prev_fi);
        end
      end else begin
        ne++;
        if (ne >= 16 && ne - 16 < 11) begin
          n_checks++;
          if (absr(f2r(result) - cosv[ne-16]) > TOL) begin
            n_errors++; $display("FAIL stall_stream[%0d]: got %h want ~%f", ne-16, result, cosv[ne-16]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    clk_en = 1'b1;
    for (int j = 0; j < 8; j++) begin
      dataa = 32'h3F800000;
      @(negedge clock);
    end
    aclr = 1'b1;
    @(negedge clock);
    aclr = 1'b0;
    n_checks++; if (result !== 32'h0) begin n_errors++; $display("FAIL midreset_result: got %h want 0", result); end
    n_checks++;
    if ({x_debug, fixed_point_input_debug, exponent_debug, rotate_index_debug} !== '0) begin
      n_errors++; $display("FAIL midreset_debug: got x=%h fpi=%h exp=%h rot=%h want all 0",
                           x_debug, fixed_point_input_debug, exponent_debug, rotate_index_debug);
    end
    for (int j = 0; j < 20; j++) begin
      dataa = 32'h0;
      @(negedge clock);
      if (j <= 13) begin
        n_checks++;
        if (result !== 32'h0) begin n_errors++; $display("FAIL midreset_drain[%0d]: got %h want 0", j, result); end
      end else if (j >= 15) begin
        n_checks++;
        if (absr(f2r(result) - 1.0) > TOL) begin
          n_errors++; $display("FAIL midreset_after[%0d]: got %h want ~1.0", j, result);
        end
      end
    end
  endtask

  task automatic test_encoders();
    logic [31:0] d32 [5] = '{32'h00080000, 32'h00000000, 32'hFFFFFFFF, 32'h00000001, 32'h80000000};
    logic [5:0]  e32 [5] = '{{1'b1, 5'd19}, {1'b0, 5'd0}, {1'b1, 5'd31}, {1'b1, 5'd0}, {1'b1, 5'd31}};
    logic [7:0]  d8  [3] = '{8'h81, 8'h00, 8'h10};
    logic [3:0]  e8  [3] = '{{1'b1, 3'd7}, {1'b0, 3'd0}, {1'b1, 3'd4}};
    for (int i = 0; i < 5; i++) begin
      pe32_data = d32[i]; #1;
      n_checks++;
      if ({pe32_valid, pe32_index} !== e32[i]) begin
        n_errors++; $display("FAIL pe32 in=%h: got valid=%b idx=%0d want valid=%b idx=%0d",
                             d32[i], pe32_valid, pe32_index, e32[i][5], e32[i][4:0]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      pe8_data = d8[i]; #1;
      n_checks++;
      if ({pe8_valid, pe8_index} !== e8[i]) begin
        n_errors++; $display("FAIL pe8 in=%h: got valid=%b idx=%0d want valid=%b idx=%0d",
                             d8[i], pe8_valid, pe8_index, e8[i][3], e8[i][2:0]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    aclr = 1'b1; clk_en = 1'b0; dataa = 32'h0;
    pe32_data = 32'h0; pe8_data = 8'h0;
    test_reset();
    test_float_to_fixed();
    test_single();
    test_stream();
    test_stall();
    test_reset_mid();
    test_encoders();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
